// File: rtl/bus_router.sv
// Single-master to N-slave request/ack router: base/mask decode with lowest-index
// priority, registered forwarding to one slave, error response on miss or timeout.
module bus_router #(
  parameter int slv_c  = 4,
  parameter int addr_w = 32,
  parameter int data_w = 32,
  parameter int to_cyc = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [slv_c-1:0][addr_w-1:0]  addr_base,
  input  logic [slv_c-1:0][addr_w-1:0]  addr_mask,
  input  logic                          m_req,
  input  logic                          m_we,
  input  logic [addr_w-1:0]             m_addr,
  input  logic [data_w-1:0]             m_wdata,
  input  logic [data_w/8-1:0]           m_be,
  output logic                          m_ack,
  output logic                          m_err,
  output logic [data_w-1:0]             m_rdata,
  output logic [slv_c-1:0]              s_req,
  output logic                          s_we,
  output logic [addr_w-1:0]             s_addr,
  output logic [data_w-1:0]             s_wdata,
  output logic [data_w/8-1:0]           s_be,
  input  logic [slv_c-1:0]              s_ack,
  input  logic [slv_c-1:0][data_w-1:0]  s_rdata,
  output logic [addr_w-1:0]             err_addr,
  output logic [1:0]                    dbg_state
);

  // Handshake: the master holds m_req (and its payload) until a one-cycle m_ack;
  // the router holds s_req[idx] until that slave pulses s_ack or the timeout hits.

  localparam int idx_w = (slv_c > 1) ? $clog2(slv_c) : 1;
  localparam int cnt_w = (to_cyc > 2) ? $clog2(to_cyc) : 1;
  localparam logic [cnt_w-1:0] to_last = cnt_w'((to_cyc > 0) ? to_cyc - 1 : 0);
  localparam bit to_en = (to_cyc != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [slv_c-1:0]   hit_vec;
  logic [idx_w-1:0]   win_idx;
  logic [idx_w-1:0]   idx;
  logic               any_hit;
  logic               sel_ack;
  logic [cnt_w-1:0]   cnt;
  logic               ld_req, ld_miss, ld_ok, ld_to;

  // Lowest index wins, so the descending scan lets lower hits overwrite higher ones.
  always_comb begin
    hit_vec = '0;
    win_idx = '0;
    for (int i = 0; i < slv_c; i++) begin
      hit_vec[i] = (m_addr & addr_mask[i]) == (addr_base[i] & addr_mask[i]);
    end
    for (int i = slv_c - 1; i >= 0; i--) begin
      if (hit_vec[i]) win_idx = idx_w'(i);
    end
  end

  assign any_hit = |hit_vec;
  assign sel_ack = s_ack[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_req    = 1'b0;
    ld_miss   = 1'b0;
    ld_ok     = 1'b0;
    ld_to     = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) begin
          if (any_hit) begin
            ld_req    = 1'b1;
            state_nxt = XFER;
          end else begin
            ld_miss   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      XFER: begin
        // Ack is checked first so an ack on the final allowed cycle still succeeds.
        if (sel_ack) begin
          ld_ok     = 1'b1;
          state_nxt = RESP;
        end else if (to_en && (cnt == to_last)) begin
          ld_to     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_req = '0;
    if (state == XFER) s_req[idx] = 1'b1;
  end

  assign m_ack     = (state == RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_be     <= '0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      err_addr <= '0;
      cnt      <= '0;
    end else begin
      if (ld_req) begin
        idx     <= win_idx;
        s_we    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_be    <= m_be;
      end
      if (ld_ok) begin
        m_rdata <= s_rdata[idx];
        m_err   <= 1'b0;
      end
      if (ld_miss) begin
        m_rdata  <= '0;
        m_err    <= 1'b1;
        err_addr <= m_addr;
      end
      if (ld_to) begin
        m_rdata  <= '0;
        m_err    <= 1'b1;
        err_addr <= s_addr;
      end
      if ((state == XFER) && (state_nxt == XFER)) cnt <= cnt + 1'b1;
      else                                        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: per-scenario tasks drive the master and
// slave side; a negedge monitor checks every m_ack against the expected queue.
module tb_bus_router;

  localparam int slv_c  = 4;
  localparam int addr_w = 32;
  localparam int data_w = 32;
  localparam int to_cyc = 8;

  logic                          clk;
  logic                          rst;
  logic [slv_c-1:0][addr_w-1:0]  addr_base;
  logic [slv_c-1:0][addr_w-1:0]  addr_mask;
  logic                          m_req;
  logic                          m_we;
  logic [addr_w-1:0]             m_addr;
  logic [data_w-1:0]             m_wdata;
  logic [data_w/8-1:0]           m_be;
  logic                          m_ack;
  logic                          m_err;
  logic [data_w-1:0]             m_rdata;
  logic [slv_c-1:0]              s_req;
  logic                          s_we;
  logic [addr_w-1:0]             s_addr;
  logic [data_w-1:0]             s_wdata;
  logic [data_w/8-1:0]           s_be;
  logic [slv_c-1:0]              s_ack;
  logic [slv_c-1:0][data_w-1:0]  s_rdata;
  logic [addr_w-1:0]             err_addr;
  logic [1:0]                    dbg_state;

  bus_router #(
    .slv_c (slv_c),
    .addr_w(addr_w),
    .data_w(data_w),
    .to_cyc(to_cyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_base(addr_base),
    .addr_mask(addr_mask),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .err_addr (err_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running sim, required finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {m_err, m_rdata} expected per transaction
  logic [data_w:0] exp_q[$];
  logic [data_w:0] mon_exp;
  int chk_cnt  = 0;
  int pass_cnt = 0;

  always @(negedge clk) begin
    if (m_ack) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_ack: got m_ack=1 err=%0b rdata=%h, required no ack", m_err, m_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_err, m_rdata} !== mon_exp)
          $display("FAIL resp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   m_err, m_rdata, mon_exp[data_w], mon_exp[data_w-1:0]);
        else
          pass_cnt++;
      end
    end
  end

  // driver tasks
  task automatic drive_req(input logic we, input logic [addr_w-1:0] a,
                           input logic [data_w-1:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = a;
    m_wdata = d;
    m_be    = be;
  endtask

  task automatic set_std_map;
    for (int i = 0; i < slv_c; i++) begin
      addr_base[i] = 32'h1000 * (i + 1);
      addr_mask[i] = 32'hFFFF_F000;
    end
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({m_ack, m_err, m_rdata, s_req} !== '0)
      $display("FAIL reset_resp: got ack=%0b err=%0b rdata=%h s_req=%b, required all 0", m_ack, m_err, m_rdata, s_req);
    else pass_cnt++;
    chk_cnt++;
    if ({s_we, s_addr, s_wdata, s_be} !== '0)
      $display("FAIL reset_fwd: got we=%0b addr=%h wdata=%h be=%b, required all 0", s_we, s_addr, s_wdata, s_be);
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== '0 || dbg_state !== 2'd0)
      $display("FAIL reset_misc: got err_addr=%h state=%0d, required 0/0", err_addr, dbg_state);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_read_hit;
    set_std_map();
    drive_req(1'b0, 32'h2004, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0010 || m_ack !== 1'b0 || s_addr !== 32'h2004)
      $display("FAIL read_xfer: got s_req=%b ack=%0b s_addr=%h, required 0010/0/00002004", s_req, m_ack, s_addr);
    else pass_cnt++;
    s_ack = 4'b0010;
    s_rdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk_cnt++;
    if (m_ack !== 1'b1 || s_req !== 4'b0000)
      $display("FAIL read_latency: got ack=%0b s_req=%b, required 1/0000", m_ack, s_req);
    else pass_cnt++;
    m_req = 1'b0;
  endtask

  task automatic test_overlap_write;
    set_std_map();
    addr_base[0] = 32'h0;  addr_mask[0] = 32'hFFFF_0000;
    addr_base[2] = 32'h0;  addr_mask[2] = 32'hFFFF_F000;
    drive_req(1'b1, 32'h0010, 32'h55, 4'b0001);
    exp_q.push_back({1'b0, 32'h1234_5678});
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0001)
      $display("FAIL overlap_prio: got s_req=%b, required 0001", s_req);
    else pass_cnt++;
    chk_cnt++;
    if (s_we !== 1'b1 || s_wdata !== 32'h55 || s_be !== 4'b0001 || s_addr !== 32'h10)
      $display("FAIL overlap_fwd: got we=%0b wdata=%h be=%b addr=%h, required 1/55/0001/10", s_we, s_wdata, s_be, s_addr);
    else pass_cnt++;
    // mid-transaction map change must not affect the routed slave
    addr_mask[0] = 32'hFFFF_FFFF;
    s_ack = 4'b0001;
    s_rdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk_cnt++;
    if (m_ack !== 1'b1)
      $display("FAIL overlap_ack: got ack=%0b, required 1", m_ack);
    else pass_cnt++;
    m_req = 1'b0;
    set_std_map();
  endtask

  task automatic test_unmapped;
    set_std_map();
    drive_req(1'b0, 32'h9000, 32'h0, 4'hF);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (m_ack !== 1'b1 || s_req !== 4'b0000)
      $display("FAIL miss_latency: got ack=%0b s_req=%b, required 1/0000", m_ack, s_req);
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== 32'h9000)
      $display("FAIL miss_err_addr: got %h, required 00009000", err_addr);
    else pass_cnt++;
    m_req = 1'b0;
  endtask

  task automatic test_timeout;
    int hi  = 0;
    int bad = 0;
    int acks = 0;
    bit got = 1'b0;
    set_std_map();
    drive_req(1'b0, 32'h4000, 32'h0, 4'hF);
    exp_q.push_back({1'b1, 32'h0});
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (s_req[3]) hi++;
      if (s_req[2:0] !== 3'b000) bad++;
      if (m_ack) got = 1'b1;
    end
    chk_cnt++;
    if (!got || hi != to_cyc || bad != 0)
      $display("FAIL timeout_len: got ack_seen=%0b s_req3_cycles=%0d stray=%0d, required 1/%0d/0", got, hi, bad, to_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== 32'h4000)
      $display("FAIL timeout_err_addr: got %h, required 00004000", err_addr);
    else pass_cnt++;
    m_req = 1'b0;
    @(posedge clk); #1;
    s_ack = 4'b1000;
    @(posedge clk); #1;
    s_ack = '0;
    repeat (4) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    chk_cnt++;
    if (acks != 0)
      $display("FAIL late_ack: got %0d m_ack pulses, required 0", acks);
    else pass_cnt++;
  endtask

  task automatic test_ack_at_limit;
    int bad = 0;
    set_std_map();
    drive_req(1'b0, 32'h2008, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'hA5A5_5A5A});
    @(negedge clk);
    for (int k = 1; k <= to_cyc; k++) begin
      @(negedge clk);
      if (s_req !== 4'b0010 || m_ack !== 1'b0) bad++;
      if (k < to_cyc) begin
        s_ack = 4'b0001;
        s_rdata[0] = 32'hDEAD_BEEF;
      end else begin
        s_ack = 4'b0010;
        s_rdata[1] = 32'hA5A5_5A5A;
      end
    end
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk_cnt++;
    if (bad != 0 || m_ack !== 1'b1)
      $display("FAIL ack_at_limit: got bad_xfer_cycles=%0d ack=%0b, required 0/1", bad, m_ack);
    else pass_cnt++;
    m_req = 1'b0;
  endtask

  task automatic test_reset_mid_xfer;
    int acks = 0;
    set_std_map();
    drive_req(1'b0, 32'h3000, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0100)
      $display("FAIL pre_reset_xfer: got s_req=%b, required 0100", s_req);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({s_req, m_ack, dbg_state, s_addr, err_addr} !== '0)
      $display("FAIL async_reset: got s_req=%b ack=%0b state=%0d s_addr=%h err_addr=%h, required all 0",
               s_req, m_ack, dbg_state, s_addr, err_addr);
    else pass_cnt++;
    m_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    chk_cnt++;
    if (acks != 0)
      $display("FAIL dropped_xact: got %0d m_ack pulses, required 0", acks);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    set_std_map();
    drive_req(1'b0, 32'h1000, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 32'h1111_0000});
    exp_q.push_back({1'b0, 32'h2222_0000});
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0001)
      $display("FAIL b2b_first_sel: got s_req=%b, required 0001", s_req);
    else pass_cnt++;
    s_ack = 4'b0001;
    s_rdata[0] = 32'h1111_0000;
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk_cnt++;
    if (m_ack !== 1'b1)
      $display("FAIL b2b_first_ack: got ack=%0b, required 1", m_ack);
    else pass_cnt++;
    drive_req(1'b0, 32'h2000, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0010 || m_ack !== 1'b0)
      $display("FAIL b2b_second_sel: got s_req=%b ack=%0b, required 0010/0", s_req, m_ack);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (s_req !== 4'b0010 || m_ack !== 1'b0)
      $display("FAIL b2b_wait: got s_req=%b ack=%0b, required 0010/0", s_req, m_ack);
    else pass_cnt++;
    s_ack = 4'b0010;
    s_rdata[1] = 32'h2222_0000;
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk_cnt++;
    if (m_ack !== 1'b1)
      $display("FAIL b2b_second_ack: got ack=%0b, required 1", m_ack);
    else pass_cnt++;
    m_req = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    s_ack   = '0;
    s_rdata = '0;
    set_std_map();
    test_reset();
    test_read_hit();
    test_overlap_write();
    test_unmapped();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_xfer();
    test_back_to_back();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Single-master to N-slave request/ack bus router. Generalises the combinational mask decoder.
- Matches each address against a per-slave base/mask pair, with deterministic priority when several slaves match.
- Registers the request and forwards it to the winning slave, then returns that slave's read data.
- Generates an error response for unmapped addresses and for slaves that never respond (timeout).
- Sits between the core bus master and the peripheral slaves.

Parameters:
- slv_c, 4, number of slave ports (1..16)
- addr_w, 32, address width
- data_w, 32, data width (multiple of 8)
- to_cyc, 255, timeout limit in cycles spent in XFER; 0 disables the timeout

Ports:
- clk  input  1  clock, all flops on the rising edge
- rst  input  1  asynchronous, active-high reset
- addr_base  input  [slv_c-1:0][addr_w-1:0]  per-slave base address
- addr_mask  input  [slv_c-1:0][addr_w-1:0]  per-slave compare mask; a 1 bit means the bit is compared
- m_req  input  1  master request; held high until m_ack
- m_we  input  1  master write enable
- m_addr  input  addr_w  master address
- m_wdata  input  data_w  master write data
- m_be  input  data_w/8  master byte enables
- m_ack  output  1  single-cycle response pulse
- m_err  output  1  error flag, valid with m_ack
- m_rdata  output  data_w  read data, valid with m_ack
- s_req  output  slv_c  one-hot slave request
- s_we  output  1  registered write enable, broadcast to all slaves
- s_addr  output  addr_w  registered address, broadcast
- s_wdata  output  data_w  registered write data, broadcast
- s_be  output  data_w/8  registered byte enables, broadcast
- s_ack  input  slv_c  per-slave acknowledge
- s_rdata  input  [slv_c-1:0][data_w-1:0]  per-slave read data
- err_addr  output  addr_w  address of the most recent errored transaction (sticky)

Behaviour:
- Match rule: slave i hits when (m_addr & addr_mask[i]) == (addr_base[i] & addr_mask[i]). This is combinational.
- Priority: when several slaves hit, the lowest index wins. A mask of all zeros matches every address, so use it as the highest-index catch-all.
- addr_base and addr_mask are sampled only on the IDLE decode edge. Changing them mid-transaction has no effect on that transaction.
- Reset values: state=IDLE; s_req=0; m_ack=0; m_err=0; m_rdata=0; s_we/s_addr/s_wdata/s_be=0; err_addr=0; timeout counter=0.
- FSM state IDLE:
  - If m_req=1 and there is a hit: latch we/addr/wdata/be into the s_* registers, latch the winner index, go to XFER.
  - If m_req=1 and there is no hit: go to RESP with m_err=1, m_rdata=0, err_addr←m_addr.
  - Otherwise stay in IDLE.
- FSM state XFER:
  - s_req[idx]=1; every other s_req bit is 0. The counter increments each cycle.
  - If s_ack[idx]=1: capture m_rdata←s_rdata[idx], set m_err=0, go to RESP.
  - Else if to_cyc≠0 and the counter reaches to_cyc-1: set m_err=1, m_rdata=0, err_addr←s_addr, go to RESP.
  - The counter clears on leaving XFER.
- FSM state RESP: m_ack=1 for exactly one cycle, s_req=0, then go to IDLE. m_req is not sampled in RESP.
- Latency from the edge that samples m_req to the m_ack high cycle:
  - Hit, slave acks in the first XFER cycle: m_ack high in the 2nd cycle after sampling. Each cycle the slave delays its ack adds one.
  - Miss: m_ack high in the cycle after sampling.
- s_ack from non-selected slaves is ignored in every state. s_ack outside XFER is ignored.
- An ack in the same cycle the timeout limit is reached counts as success (ack wins).
- After a timeout, a late s_ack from that slave is ignored.
- Write transactions return m_rdata equal to whatever the slave drives with its ack; there is no masking.
- Reset asserted mid-transaction forces the reset values immediately (asynchronously); the in-flight transaction is dropped with no m_ack.
- The master must drop m_req, or present a new request, in the cycle after m_ack. A held m_req is treated as a new request in IDLE.

Test Plan:
- Bases 0x1000/0x2000/0x3000/0x4000, masks 0xFFFFF000. Read 0x2004; slave1 acks in the first XFER cycle with 0xCAFEF00D -> s_req=4'b0010 for one cycle, m_ack two cycles after sampling, m_rdata=0xCAFEF00D, m_err=0.
- Overlap: slave0 mask 0xFFFF0000 base 0x0000, slave2 mask 0xFFFFF000 base 0x0000. Write 0x0010 wdata=0x55 be=4'b0001 -> only s_req[0], s_wdata=0x55, s_be=4'b0001.
- Unmapped address 0x9000 -> no s_req, m_ack one cycle after sampling, m_err=1, m_rdata=0, err_addr=0x9000.
- to_cyc=8, slave3 never acks -> s_req[3] high for exactly 8 cycles, then m_ack with m_err=1 and err_addr=0x4000. A later s_ack[3] pulse produces no m_ack.
- Slave acks exactly on the 8th XFER cycle with to_cyc=8 -> m_err=0 and data returned; a spurious s_ack[0] during slave1's XFER is ignored.
- Assert rst during XFER, then issue back-to-back requests to slaves 0 and 1 -> all outputs zero at once, no m_ack; both new transactions complete correctly, in order.
